rv32_alu: RTL and testbench

32-bit integer ALU for the RV32 single-cycle/pipelined datapath, sitting between the register-file/immediate operand muxes and the writeback/branch logic. It takes two 32-bit operands and a 3-bit operation code. It produces a registered 32-bit result plus four registered status flags (zero, negative, carry, overflow). Branch comparison uses these flags.

---
 rtl/rv32_alu.sv | 103 ++++++++++
 tb/tb_rv32_alu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rv32_alu.sv
// Purpose : RV32 integer ALU (add/sub/and/or/xor/slt/sll/srl) with registered result and Z/N/C/V flags.
// Latency : 1 cycle; outputs reflect A/B/ALUControl sampled at the previous rising edge.
// Backpr. : none; a new operation is accepted every cycle, no handshake or stall.
//
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset (clears all outputs)
//   A, B, ALUControl   operands and 3-bit operation select
//   Result             registered operation result
//   Zero, Negative     registered result==0 / result MSB, valid for every op
//   Carry, Overflow    registered adder carry-out (no-borrow on sub) / signed overflow; 0 for non-arith ops
module rv32_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt_bit;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;

    // Both adders are kept as 33-bit sums so bit WIDTH is the carry-out directly.
    // Subtraction as A + ~B + 1 makes that carry-out the "no borrow" flag.
    assign add_sum = {1'b0, A} + {1'b0, B};
    assign sub_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);

    // Signed less-than from the subtractor: the sign of A-B is wrong exactly when it overflowed.
    assign slt_bit = sub_sum[WIDTH-1] ^ sub_ovf;

    // Only the low log2(WIDTH) bits of B select the shift distance.
    assign shamt = B[SHW-1:0];

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                res_c   = add_sum[WIDTH-1:0];
                carry_c = add_sum[WIDTH];
                ovf_c   = add_ovf;
            end
            OP_SUB: begin
                res_c   = sub_sum[WIDTH-1:0];
                carry_c = sub_sum[WIDTH];
                ovf_c   = sub_ovf;
            end
            OP_AND:  res_c = A & B;
            OP_OR:   res_c = A | B;
            OP_XOR:  res_c = A ^ B;
            OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLL:  res_c = A << shamt;
            OP_SRL:  res_c = A >> shamt;
            default: res_c = '0;
        endcase
    end

    // Reset wins over capture, so an operation presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Result   <= '0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            Result   <= res_c;
            Zero     <= (res_c == '0);
            Negative <= res_c[WIDTH-1];
            Carry    <= carry_c;
            Overflow <= ovf_c;
        end
    end

endmodule

// File: tb/tb_rv32_alu.sv
module tb_rv32_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] Result;
    logic        Zero;
    logic        Negative;
    logic        Carry;
    logic        Overflow;

    int checks = 0;
    int fails  = 0;

    // Expected {Result, Zero, Negative, Carry, Overflow} for the edge just taken.
    logic [35:0] exp_out;
    logic        exp_vld = 1'b0;

    rv32_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (a),
        .B          (b),
        .ALUControl (op),
        .Result     (Result),
        .Zero       (Zero),
        .Negative   (Negative),
        .Carry      (Carry),
        .Overflow   (Overflow)
    );

    always #5 clk = ~clk;

    // Reference ALU using 64-bit integer arithmetic: carry is an unsigned
    // range check, overflow is "true signed result does not fit in 32 bits",
    // and SLT is a plain signed comparison.
    function automatic logic [35:0] model(input logic [31:0] ia, input logic [31:0] ib,
                                          input logic [2:0] iop);
        longint      sa;
        longint      sb;
        longint      sr;
        logic [63:0] wide;
        logic [31:0] r;
        logic signed [31:0] rs;
        logic        c;
        logic        v;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        sr = 0;
        r  = 32'h0;
        c  = 1'b0;
        v  = 1'b0;
        case (iop)
            3'd0: begin
                wide = {32'h0, ia} + {32'h0, ib};
                r    = wide[31:0];
                c    = (wide > 64'hFFFF_FFFF);
                sr   = sa + sb;
                rs   = r;
                v    = (sr != longint'(rs));
            end
            3'd1: begin
                r  = ia - ib;
                c  = (ia >= ib);
                sr = sa - sb;
                rs = r;
                v  = (sr != longint'(rs));
            end
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: r = ia << ib[4:0];
            default: r = ia >> ib[4:0];
        endcase
        return {r, (r == 32'h0), r[31], c, v};
    endfunction

    // Capture the expectation from the inputs the DUT sees at each edge.
    always @(posedge clk) begin
        if (!rst_n) exp_out = 36'h0;
        else        exp_out = model(a, b, op);
        exp_vld = 1'b1;
    end

    // Per-cycle compare against the model, half a cycle after the edge.
    always @(negedge clk) begin
        if (exp_vld) begin
            checks++;
            if ({Result, Zero, Negative, Carry, Overflow} !== exp_out) begin
                fails++;
                $display("FAIL model t=%0t: got R=%h ZNCV=%b, expected R=%h ZNCV=%b",
                         $time, Result, {Zero, Negative, Carry, Overflow},
                         exp_out[35:4], exp_out[3:0]);
            end
        end
    end

    task automatic check_out(input string name, input logic [31:0] er, input logic [3:0] ef);
        checks++;
        if (Result !== er || {Zero, Negative, Carry, Overflow} !== ef) begin
            fails++;
            $display("FAIL %s: got R=%h ZNCV=%b, expected R=%h ZNCV=%b",
                     name, Result, {Zero, Negative, Carry, Overflow}, er, ef);
        end
    endtask

    // Drive one op after a falling edge, check the registered result just after the next rising edge.
    task automatic run_op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [2:0] iop, input logic [31:0] er, input logic [3:0] ef);
        @(negedge clk);
        a  = ia;
        b  = ib;
        op = iop;
        @(posedge clk);
        #1;
        check_out(name, er, ef);
    endtask

    task automatic model_pin(input string name, input logic [35:0] got, input logic [35:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: model gave %h, expected %h", name, got, want);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a     = 32'hFFFF_FFFF;
        b     = 32'h1;
        op    = 3'b000;

        // Pin the reference model against hand-computed results.
        model_pin("model_add_ovf", model(32'h7FFF_FFFF, 32'h1, 3'd0), {32'h8000_0000, 4'b0101});
        model_pin("model_sub_ovf", model(32'h8000_0000, 32'h1, 3'd1), {32'h7FFF_FFFF, 4'b0011});
        model_pin("model_slt_ovf", model(32'h8000_0000, 32'h7FFF_FFFF, 3'd5), {32'h1, 4'b0000});

        // Two reset edges with non-zero inputs present.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_out("reset", 32'h0, 4'b0000);

        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_1_2",      32'h1,         32'h2,         3'b000, 32'h3,         4'b0000);
        run_op("sub_5_5",      32'h5,         32'h5,         3'b001, 32'h0,         4'b1010);
        run_op("sub_3_5",      32'h3,         32'h5,         3'b001, 32'hFFFF_FFFE, 4'b0100);
        run_op("add_max_1",    32'h7FFF_FFFF, 32'h1,         3'b000, 32'h8000_0000, 4'b0101);
        run_op("add_ff_1",     32'hFFFF_FFFF, 32'h1,         3'b000, 32'h0,         4'b1010);
        run_op("sub_min_1",    32'h8000_0000, 32'h1,         3'b001, 32'h7FFF_FFFF, 4'b0011);
        run_op("and",          32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 32'hF000_F000, 4'b0100);
        run_op("or",           32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 32'hFFF0_FFF0, 4'b0100);
        run_op("xor",          32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'h0FF0_0FF0, 4'b0000);
        run_op("slt_m1_1",     32'hFFFF_FFFF, 32'h1,         3'b101, 32'h1,         4'b0000);
        run_op("slt_1_m1",     32'h1,         32'hFFFF_FFFF, 3'b101, 32'h0,         4'b1000);
        run_op("slt_min_max",  32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 32'h1,         4'b0000);
        run_op("sll_31",       32'h1,         32'h0000_003F, 3'b110, 32'h8000_0000, 4'b0100);
        run_op("srl_4",        32'h8000_0000, 32'h4,         3'b111, 32'h0800_0000, 4'b0000);
        run_op("srl_31",       32'h8000_0000, 32'h1F,        3'b111, 32'h1,         4'b0000);
        run_op("sll_0",        32'h1234_5678, 32'h20,        3'b110, 32'h1234_5678, 4'b0000);
        run_op("add_zero",     32'h0,         32'h0,         3'b000, 32'h0,         4'b1010 & 4'b1000);

        // Reset mid-stream: the op presented with reset low is discarded.
        @(negedge clk);
        rst_n = 1'b0;
        a     = 32'hFFFF_FFFF;
        b     = 32'h1;
        op    = 3'b000;
        @(posedge clk);
        #1;
        check_out("mid_reset", 32'h0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("post_reset_add", 32'h10, 32'h20, 3'b000, 32'h30, 4'b0000);

        // Back-to-back random ops, checked every cycle by the model compare.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a  = $urandom;
            b  = (i % 4 == 0) ? $urandom_range(0, 40) : $urandom;
            op = 3'($urandom_range(0, 7));
        end
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
